// File: rtl/lsu_mmio_bridge.sv
// Purpose: bridges single core load/store accesses onto a word-wide MMIO request/ready bus.
// Latency: request accepted at E0, bus_valid E0..Ek (ready sampled at Ek), core_done for one cycle after Ek.
// Backpressure: bus_valid and bus fields hold until bus_ready or a TIMEOUT abort; core_req is ignored while busy.
module lsu_mmio_bridge #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        core_req,
   input  logic [31:0] core_addr,
   input  logic [31:0] core_wdata,
   input  logic        core_we,
   input  logic [1:0]  core_size,
   input  logic        core_unsigned,
   output logic        core_busy,
   output logic        core_done,
   output logic        core_err,
   output logic [31:0] core_rdata,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   output logic        bus_we,
   output logic        bus_valid,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ready
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

   localparam logic [7:0] TMO = 8'(TIMEOUT);

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        we_q, we_d;
   logic        uns_q, uns_d;
   logic        err_q, err_d;
   logic [1:0]  size_q, size_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        legal;
   logic [31:0] lane;
   logic [31:0] load_val;

   // Alignment check on the raw request; size 11 never matches
   always_comb begin
      legal = 1'b0;
      case (core_size)
         2'b00:   legal = 1'b1;
         2'b01:   legal = ~core_addr[0];
         2'b10:   legal = (core_addr[1:0] == 2'b00);
         default: legal = 1'b0;
      endcase
   end

   // Pick the addressed lane out of the read word and extend it to 32 bits
   always_comb begin
      lane     = bus_rdata >> {addr_q[1:0], 3'b000};
      load_val = lane;
      case (size_q)
         2'b00:   load_val = uns_q ? {24'd0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
         2'b01:   load_val = uns_q ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
         default: load_val = lane;
      endcase
   end

   // Next-state logic: accept in IDLE, wait for ready or timeout in REQ, single-cycle DONE
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (core_req) begin
               addr_d  = core_addr;
               wdata_d = core_wdata;
               we_d    = core_we;
               size_d  = core_size;
               uns_d   = core_unsigned;
               cnt_d   = 8'd0;
               rdata_d = 32'd0;
               if (legal) begin
                  state_d = REQ;
                  err_d   = 1'b0;
               end else begin
                  state_d = DONE;
                  err_d   = 1'b1;
               end
            end
         end
         REQ: begin
            // ready wins over a timeout landing on the same edge
            if (bus_ready) begin
               state_d = DONE;
               err_d   = 1'b0;
               rdata_d = we_q ? 32'd0 : load_val;
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q + 8'd1 == TMO) begin
                  state_d = DONE;
                  err_d   = 1'b1;
                  rdata_d = 32'd0;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and latched-request registers; reset clears everything immediately
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         we_q    <= 1'b0;
         size_q  <= 2'd0;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

   // Byte enables and lane-replicated store data from the latched request
   always_comb begin
      bus_wstrb = 4'b0000;
      bus_wdata = wdata_q;
      case (size_q)
         2'b00: begin
            bus_wdata = {4{wdata_q[7:0]}};
            if (we_q) bus_wstrb = 4'b0001 << addr_q[1:0];
         end
         2'b01: begin
            bus_wdata = {2{wdata_q[15:0]}};
            if (we_q) bus_wstrb = 4'b0011 << addr_q[1:0];
         end
         2'b10: begin
            if (we_q) bus_wstrb = 4'b1111;
         end
         default: bus_wstrb = 4'b0000;
      endcase
   end

   assign bus_addr   = {addr_q[31:2], 2'b00};
   assign bus_we     = we_q;
   assign bus_valid  = (state_q == REQ);
   assign core_busy  = (state_q != IDLE);
   assign core_done  = (state_q == DONE);
   assign core_err   = err_q & (state_q == DONE);
   assign core_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_mmio_bridge.sv
module tb_lsu_mmio_bridge;
   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        core_req;
   logic [31:0] core_addr, core_wdata;
   logic        core_we;
   logic [1:0]  core_size;
   logic        core_unsigned;
   logic        core_busy, core_done, core_err;
   logic [31:0] core_rdata;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_wstrb;
   logic        bus_we, bus_valid;
   logic [31:0] bus_rdata;
   logic        bus_ready;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   int          obs_vcyc, obs_done_len;
   logic        obs_held, obs_err, obs_we, obs_busy_after;
   logic [31:0] obs_addr, obs_wdata, obs_rdata;
   logic [3:0]  obs_wstrb;

   always #5 clk = ~clk;

   lsu_mmio_bridge #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_we(core_we), .core_size(core_size), .core_unsigned(core_unsigned),
      .core_busy(core_busy), .core_done(core_done), .core_err(core_err), .core_rdata(core_rdata),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_we(bus_we),
      .bus_valid(bus_valid), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
   );

   // ---------------- reference model (plain arithmetic) ----------------
   function automatic bit m_legal(input logic [31:0] a, input logic [1:0] sz);
      case (sz)
         2'd0:    return 1'b1;
         2'd1:    return (a % 2) == 0;
         2'd2:    return (a % 4) == 0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] m_wstrb(input logic [31:0] a, input logic we, input logic [1:0] sz);
      int unsigned off;
      off = a % 4;
      if (!we) return 4'd0;
      case (sz)
         2'd0:    return 4'(1 << off);
         2'd1:    return 4'(3 << off);
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [1:0] sz);
      case (sz)
         2'd0:    return (wd % 256) * 32'h0101_0101;
         2'd1:    return (wd % 65536) * 32'h0001_0001;
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz,
                                          input logic un, input logic [31:0] rd);
      int unsigned off;
      logic [31:0] v;
      off = a % 4;
      v   = rd / (32'd1 << (8 * off));
      case (sz)
         2'd0: begin
            v = v % 256;
            if (!un && v >= 128) v = v + 32'hFFFF_FF00;
         end
         2'd1: begin
            v = v % 65536;
            if (!un && v >= 32768) v = v + 32'hFFFF_0000;
         end
         default: ;
      endcase
      return v;
   endfunction

   // ---------------- transaction driver (observes only) ----------------
   task automatic run_access(input logic [31:0] a, input logic [31:0] wd, input logic we,
                             input logic [1:0] sz, input logic un, input logic [31:0] rd, input int d);
      int guard;
      obs_vcyc = 0; obs_held = 1'b1; obs_done_len = 0;
      obs_addr = 32'd0; obs_wdata = 32'd0; obs_wstrb = 4'd0; obs_we = 1'b0;
      core_req = 1'b1; core_addr = a; core_wdata = wd; core_we = we;
      core_size = sz; core_unsigned = un;
      @(posedge clk); #1;
      guard = 0;
      while (bus_valid && guard < 50) begin
         if (obs_vcyc == 0) begin
            obs_addr = bus_addr; obs_wdata = bus_wdata; obs_wstrb = bus_wstrb; obs_we = bus_we;
         end else if ({bus_addr, bus_wdata, bus_wstrb, bus_we} !== {obs_addr, obs_wdata, obs_wstrb, obs_we}) begin
            obs_held = 1'b0;
         end
         core_req = 1'($urandom); core_addr = $urandom; core_wdata = $urandom;
         core_we = 1'($urandom); core_size = 2'($urandom); core_unsigned = 1'($urandom);
         bus_ready = (obs_vcyc == d);
         bus_rdata = (obs_vcyc == d) ? rd : $urandom;
         obs_vcyc++;
         guard++;
         @(posedge clk); #1;
      end
      bus_ready = 1'($urandom);
      core_req  = 1'($urandom); core_addr = $urandom; core_size = 2'($urandom);
      obs_done_len = core_done ? 1 : 0;
      obs_err   = core_err;
      obs_rdata = core_rdata;
      @(posedge clk); #1;
      if (core_done) obs_done_len++;
      obs_busy_after = core_busy;
      core_req  = 1'b0;
      bus_ready = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [104:0] outs;
      rst = 1'b0; core_req = 1'b0; core_addr = 32'd0; core_wdata = 32'd0; core_we = 1'b0;
      core_size = 2'd0; core_unsigned = 1'b0; bus_rdata = 32'd0; bus_ready = 1'b0;
      #2;
      outs = {core_busy, core_done, core_err, core_rdata, bus_addr, bus_wdata, bus_wstrb, bus_we, bus_valid};
      chk_cnt++;
      if (outs !== 105'd0) $display("FAIL reset_outputs: got %h want 0", outs);
      else pass_cnt++;
      core_req = 1'b1; core_addr = 32'h4000_4008; core_we = 1'b1; core_size = 2'd2; core_wdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      outs = {core_busy, core_done, core_err, core_rdata, bus_addr, bus_wdata, bus_wstrb, bus_we, bus_valid};
      chk_cnt++;
      if (outs !== 105'd0) $display("FAIL reset_holds_req: got %h want 0", outs);
      else pass_cnt++;
      core_req = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_word_store();
      run_access(32'h4000_4008, 32'hDEAD_BEEF, 1'b1, 2'b10, 1'b0, 32'h0, 2);
      chk_cnt++;
      if ({obs_addr, obs_wstrb, obs_wdata, obs_we} !== {32'h4000_4008, 4'b1111, 32'hDEAD_BEEF, 1'b1})
         $display("FAIL word_store_bus: got %h %b %h %b want 40004008 1111 deadbeef 1", obs_addr, obs_wstrb, obs_wdata, obs_we);
      else pass_cnt++;
      chk_cnt++;
      if ({obs_held, obs_vcyc} !== {1'b1, 32'd3}) $display("FAIL word_store_hold: got held=%b vcyc=%0d want 1 3", obs_held, obs_vcyc);
      else pass_cnt++;
      chk_cnt++;
      if ({obs_done_len, obs_err, obs_rdata, obs_busy_after} !== {32'd1, 1'b0, 32'd0, 1'b0})
         $display("FAIL word_store_done: got len=%0d err=%b rdata=%h busy=%b want 1 0 0 0", obs_done_len, obs_err, obs_rdata, obs_busy_after);
      else pass_cnt++;
   endtask

   task automatic test_byte_load();
      run_access(32'h4000_4003, 32'h0, 1'b0, 2'b00, 1'b0, 32'h80FF_0000, 1);
      chk_cnt++;
      if ({obs_addr, obs_wstrb, obs_we} !== {32'h4000_4000, 4'b0000, 1'b0})
         $display("FAIL byte_load_bus: got %h %b %b want 40004000 0000 0", obs_addr, obs_wstrb, obs_we);
      else pass_cnt++;
      chk_cnt++;
      if ({obs_vcyc, obs_err, obs_rdata} !== {32'd2, 1'b0, 32'hFFFF_FF80})
         $display("FAIL byte_load_signed: got vcyc=%0d err=%b rdata=%h want 2 0 ffffff80", obs_vcyc, obs_err, obs_rdata);
      else pass_cnt++;
      run_access(32'h4000_4003, 32'h0, 1'b0, 2'b00, 1'b1, 32'h80FF_0000, 0);
      chk_cnt++;
      if ({obs_err, obs_rdata, obs_done_len} !== {1'b0, 32'h0000_0080, 32'd1})
         $display("FAIL byte_load_unsigned: got err=%b rdata=%h len=%0d want 0 00000080 1", obs_err, obs_rdata, obs_done_len);
      else pass_cnt++;
   endtask

   task automatic test_half_store();
      run_access(32'h4000_4002, 32'h0000_1234, 1'b1, 2'b01, 1'b0, 32'h0, 0);
      chk_cnt++;
      if ({obs_wstrb, obs_wdata, obs_addr} !== {4'b1100, 32'h1234_1234, 32'h4000_4000})
         $display("FAIL half_store_bus: got %b %h %h want 1100 12341234 40004000", obs_wstrb, obs_wdata, obs_addr);
      else pass_cnt++;
   endtask

   task automatic test_misaligned();
      run_access(32'h4000_4001, 32'h1, 1'b1, 2'b10, 1'b0, 32'h0, 0);
      chk_cnt++;
      if ({obs_vcyc, obs_done_len, obs_err, obs_rdata} !== {32'd0, 32'd1, 1'b1, 32'd0})
         $display("FAIL misaligned_word: got vcyc=%0d len=%0d err=%b rdata=%h want 0 1 1 0", obs_vcyc, obs_done_len, obs_err, obs_rdata);
      else pass_cnt++;
      run_access(32'h4000_4004, 32'h1, 1'b0, 2'b11, 1'b0, 32'h0, 0);
      chk_cnt++;
      if ({obs_vcyc, obs_err, obs_rdata} !== {32'd0, 1'b1, 32'd0})
         $display("FAIL illegal_size: got vcyc=%0d err=%b rdata=%h want 0 1 0", obs_vcyc, obs_err, obs_rdata);
      else pass_cnt++;
   endtask

   task automatic test_timeout();
      int late_seen;
      run_access(32'h4000_4010, 32'h5, 1'b0, 2'b10, 1'b0, 32'h1234_5678, 1000);
      chk_cnt++;
      if ({obs_vcyc, obs_done_len, obs_err, obs_rdata} !== {32'd4, 32'd1, 1'b1, 32'd0})
         $display("FAIL timeout_abort: got vcyc=%0d len=%0d err=%b rdata=%h want 4 1 1 0", obs_vcyc, obs_done_len, obs_err, obs_rdata);
      else pass_cnt++;
      late_seen = 0;
      bus_ready = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         if (core_done || bus_valid || core_busy) late_seen++;
      end
      bus_ready = 1'b0;
      chk_cnt++;
      if (late_seen !== 0) $display("FAIL timeout_late_ready: got %0d active cycles want 0", late_seen);
      else pass_cnt++;
      // ready in the very cycle the count would expire completes normally
      run_access(32'h4000_4020, 32'h0, 1'b0, 2'b10, 1'b0, 32'hCAFE_F00D, TMO - 1);
      chk_cnt++;
      if ({obs_vcyc, obs_err, obs_rdata} !== {32'(TMO), 1'b0, 32'hCAFE_F00D})
         $display("FAIL ready_at_timeout: got vcyc=%0d err=%b rdata=%h want %0d 0 cafef00d", obs_vcyc, obs_err, obs_rdata, TMO);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_req();
      logic [104:0] outs;
      int seen;
      core_req = 1'b1; core_addr = 32'h4000_4008; core_we = 1'b0; core_size = 2'd2; core_unsigned = 1'b0;
      bus_ready = 1'b0;
      @(posedge clk); #1;
      core_req = 1'b0;
      chk_cnt++;
      if (bus_valid !== 1'b1) $display("FAIL rst_mid_req_valid_before: got %b want 1", bus_valid);
      else pass_cnt++;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      outs = {core_busy, core_done, core_err, core_rdata, bus_addr, bus_wdata, bus_wstrb, bus_we, bus_valid};
      chk_cnt++;
      if (outs !== 105'd0) $display("FAIL rst_mid_req_async: got %h want 0", outs);
      else pass_cnt++;
      #2;
      rst = 1'b1;
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (core_done || bus_valid || core_busy) seen++;
      end
      chk_cnt++;
      if (seen !== 0) $display("FAIL rst_mid_req_no_retry: got %0d active cycles want 0", seen);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int n_done, n_valid, n_bad;
      n_done = 0; n_valid = 0; n_bad = 0;
      core_req = 1'b1; core_addr = 32'h4000_4001; core_we = 1'b0; core_size = 2'd0; core_unsigned = 1'b1;
      bus_ready = 1'b1; bus_rdata = 32'h1122_3344;
      repeat (12) begin
         @(posedge clk); #1;
         if (bus_valid) n_valid++;
         if (core_done) begin
            n_done++;
            if (core_rdata !== 32'h0000_0033 || core_err !== 1'b0) n_bad++;
         end
      end
      core_req = 1'b0; bus_ready = 1'b0;
      chk_cnt++;
      if ({n_done, n_valid} !== {32'd4, 32'd4})
         $display("FAIL back_to_back_rate: got done=%0d valid=%0d want 4 4", n_done, n_valid);
      else pass_cnt++;
      chk_cnt++;
      if (n_bad !== 0) $display("FAIL back_to_back_data: got %0d bad completions want 0", n_bad);
      else pass_cnt++;
   endtask

   task automatic test_random();
      logic [31:0] a, wd, rd, e_rdata;
      logic        we, un, e_err, lg;
      logic [1:0]  sz;
      int          d, e_vcyc;
      for (int i = 0; i < 150; i++) begin
         a  = $urandom; wd = $urandom; rd = $urandom;
         we = 1'($urandom); un = 1'($urandom);
         sz = 2'($urandom_range(0, 3));
         d  = $urandom_range(0, 5);
         lg = m_legal(a, sz);
         e_vcyc  = !lg ? 0 : (d < TMO ? d + 1 : TMO);
         e_err   = !lg || d >= TMO;
         e_rdata = (e_err || we) ? 32'd0 : m_load(a, sz, un, rd);
         run_access(a, wd, we, sz, un, rd, d);
         chk_cnt++;
         if ({obs_vcyc, obs_err, obs_rdata} !== {e_vcyc, e_err, e_rdata})
            $display("FAIL rand_result[%0d]: got vcyc=%0d err=%b rdata=%h want %0d %b %h", i, obs_vcyc, obs_err, obs_rdata, e_vcyc, e_err, e_rdata);
         else pass_cnt++;
         chk_cnt++;
         if ({obs_done_len, obs_busy_after} !== {32'd1, 1'b0})
            $display("FAIL rand_done_pulse[%0d]: got len=%0d busy=%b want 1 0", i, obs_done_len, obs_busy_after);
         else pass_cnt++;
         if (lg) begin
            chk_cnt++;
            if ({obs_addr, obs_wstrb, obs_wdata, obs_we, obs_held} !==
                {a & 32'hFFFF_FFFC, m_wstrb(a, we, sz), m_wdata(wd, sz), we, 1'b1})
               $display("FAIL rand_bus[%0d]: got %h %b %h %b held=%b want %h %b %h %b 1", i,
                        obs_addr, obs_wstrb, obs_wdata, obs_we, obs_held,
                        a & 32'hFFFF_FFFC, m_wstrb(a, we, sz), m_wdata(wd, sz), we);
            else pass_cnt++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_word_store();
      test_byte_load();
      test_half_store();
      test_misaligned();
      test_timeout();
      test_reset_mid_req();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/lsu_mmio_bridge.md
LSU_MMIO_BRIDGE -- requirements
Module: lsu_mmio_bridge

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the number of consecutive bus_valid-high/bus_ready-low cycles before the access is aborted (range 1..255).
REQ-002 The block SHALL have these ports, each described as name, direction, width, meaning:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- core_req  in  1  access request, sampled only when core_busy=0.
- core_addr  in  32  byte address.
- core_wdata  in  32  store data, right-aligned.
- core_we  in  1  1=store, 0=load.
- core_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- core_unsigned  in  1  load zero-extend when 1, sign-extend when 0.
- core_busy  out  1  access in progress.
- core_done  out  1  one-cycle completion pulse.
- core_err  out  1  error qualifier, valid with core_done.
- core_rdata  out  32  load result, valid with core_done.
- bus_addr  out  32  word-aligned address to the MMIO decoder.
- bus_wdata  out  32  lane-replicated store data.
- bus_wstrb  out  4  byte enables.
- bus_we  out  1  write enable.
- bus_valid  out  1  request valid.
- bus_rdata  in  32  read data from the decoder.
- bus_ready  in  1  completion from the decoder.

Function
REQ-003 The FSM SHALL have states IDLE, REQ, DONE; core_busy SHALL be 1 in REQ and DONE and 0 in IDLE.
REQ-004 In IDLE with core_req=1, the block SHALL latch the addr, wdata, we, size and unsigned inputs and check alignment. Half requires addr[0]=0. Word requires addr[1:0]=00. Size 11 is always illegal.
REQ-005 On a legal request the block SHALL enter REQ at the next edge with bus_valid=1, and SHALL hold all bus_* outputs constant until bus_ready=1 is sampled.
REQ-006 On an illegal request the block SHALL go directly to DONE with core_err=1 and core_rdata=0, and SHALL never assert bus_valid.
REQ-007 bus_addr SHALL equal {core_addr[31:2],2'b00}.
REQ-008 For stores, bus_wstrb SHALL be 0001<<off for a byte, 0011<<off for a half, and 1111 for a word, where off=core_addr[1:0]. For loads, bus_wstrb SHALL be 0000.
REQ-009 bus_wdata SHALL be the byte replicated 4x, the half replicated 2x, or the word unchanged; bus_we SHALL equal the latched core_we.
REQ-010 On the edge where bus_ready=1 is sampled in REQ, the block SHALL:
- drop bus_valid;
- enter DONE;
- for loads, register core_rdata from bus_rdata lane off, sign- or zero-extended per size and unsigned;
- for stores, set core_rdata=0.
REQ-011 DONE SHALL last exactly one cycle with core_done=1, then return to IDLE. core_req during DONE SHALL be ignored, so the minimum request spacing is 3 cycles.
REQ-012 A cycle counter SHALL clear on entry to REQ and increment for each REQ cycle with bus_ready=0. When it reaches TIMEOUT, the block SHALL drop bus_valid and enter DONE with core_err=1 and core_rdata=0.
REQ-013 If bus_ready=1 arrives in the same cycle the counter reaches TIMEOUT, the access SHALL complete normally with core_err=0.
REQ-014 bus_ready SHALL be ignored in IDLE and DONE. core_req SHALL be ignored while core_busy=1.
REQ-015 Latency SHALL be as follows, with req accepted at edge E0 and ready sampled at edge Ek: bus_valid high from E0 to Ek, and core_done high between Ek and Ek+1. With a decoder that responds one cycle after valid, core_done rises 2 edges after E0.

Reset
REQ-016 While rst=0, the state SHALL be IDLE, the counter 0, and every output 0 (core_busy, core_done, core_err, core_rdata, bus_addr, bus_wdata, bus_wstrb, bus_we, bus_valid), taking effect immediately without a clock.
REQ-017 A reset asserted in REQ SHALL drop bus_valid asynchronously. No core_done SHALL follow, and the aborted access SHALL not be retried.

Verification
REQ-018 The bench SHALL cover the following directed scenarios:
- Word store: addr=0x4000_4008, wdata=0xDEADBEEF, size=10 -> bus_addr=0x4000_4008, wstrb=1111, valid held until ready; core_done 1 cycle, err=0.
- Byte signed load: addr=0x4000_4003, bus_rdata=0x80FF_0000 -> wstrb=0000, bus_addr=0x4000_4000, core_rdata=0xFFFF_FF80. Unsigned variant -> 0x0000_0080.
- Half store: addr=0x4000_4002, wdata=0x0000_1234 -> wstrb=1100, bus_wdata=0x1234_1234.
- Misaligned word: addr=0x4000_4001 -> bus_valid never asserted; core_done with err=1 on the next cycle.
- Timeout: TIMEOUT=4, ready held 0 -> valid for 4 cycles then drops; core_done with err=1, rdata=0. A late ready pulse is ignored.
- Reset mid-REQ: rst low while valid=1 -> bus_valid=0 immediately; no core_done after reset release.
